// File: rtl/frame_buf_pkg.sv
// Shared definitions for the ping-pong frame buffer controller.
//   NUM_BANKS / BANK_W : bank count and bank-select width
//   wr/rd state codes  : writer and reader FSM encodings
//   bank_mask()        : one-hot mask for a bank index
package frame_buf_pkg;

  localparam int NUM_BANKS = 2;
  localparam int BANK_W    = $clog2(NUM_BANKS);

  typedef logic [0:0] fsm_state_t;

  localparam logic [0:0] W_FILL = 1'b0;
  localparam logic [0:0] W_WAIT = 1'b1;

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_READ = 1'b1;

  function automatic logic [NUM_BANKS-1:0] bank_mask(input logic [BANK_W-1:0] bank);
    logic [NUM_BANKS-1:0] m;
    m       = '0;
    m[bank] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/frame_addr_cnt.sv
// Word counter for one side (writer or reader) of the frame buffer.
//   clk, reset : clock, async active-high reset
//   inc        : advance count by one
//   clr        : synchronous clear (has priority over inc)
//   cnt        : current word index
//   last       : cnt is at the final word of a frame (MEM_DEPTH-1)
module frame_addr_cnt #(
  parameter int ADDR_WIDTH = 3,
  parameter int MEM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc,
  input  logic                  clr,
  output logic [ADDR_WIDTH-1:0] cnt,
  output logic                  last
);

  assign last = (cnt == ADDR_WIDTH'(MEM_DEPTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc)
      cnt <= cnt + ADDR_WIDTH'(1);
  end

endmodule

// File: rtl/frame_buf_ctrl.sv
// Ping-pong frame buffer controller. A writer fills one bank while a reader
// drains the other; a bank is handed over once a whole frame is in it.
//   clk, reset            : clock, async active-high reset
//   wr_req / rd_req       : source offers a word / sink wants a word
//   wr_en, wr_addr        : registered write strobe and {bank, word}
//   rd_en, rd_addr        : registered read strobe and {bank, word}
//   frame_rdy             : reader's current bank holds a complete frame
//   wr_drop / rd_underrun : one-cycle pulse per rejected request
//   frame_cnt             : completed written frames, wraps at 255
module frame_buf_ctrl
  import frame_buf_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int MEM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_req,
  input  logic                rd_req,
  output logic                wr_en,
  output logic [ADDR_WIDTH:0] wr_addr,
  output logic                rd_en,
  output logic [ADDR_WIDTH:0] rd_addr,
  output logic                frame_rdy,
  output logic                wr_drop,
  output logic                rd_underrun,
  output logic [7:0]          frame_cnt
);

  logic [BANK_W-1:0]     wb, rb, wb_next, rb_next;
  logic [NUM_BANKS-1:0]  full, full_nxt, set_mask, clr_mask;
  logic [ADDR_WIDTH-1:0] wr_cnt, rd_cnt;
  logic                  wr_last, rd_last;
  fsm_state_t            wr_state, rd_state;
  logic                  wr_acc, wr_rej, rd_acc, rd_rej, wr_done, rd_done;

  assign wr_acc  = wr_req && (wr_state == W_FILL);
  assign wr_rej  = wr_req && (wr_state == W_WAIT);
  assign rd_acc  = rd_req && full[rb];
  assign rd_rej  = rd_req && !full[rb];
  assign wr_done = wr_acc && wr_last;
  assign rd_done = rd_acc && rd_last;

  assign wb_next = wb + BANK_W'(1);
  assign rb_next = rb + BANK_W'(1);

  // Set and clear never hit the same bank: the writer only completes a bank
  // that is not full, the reader only completes one that is.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (wr_done) set_mask = bank_mask(wb);
    if (rd_done) clr_mask = bank_mask(rb);
    full_nxt = (full | set_mask) & ~clr_mask;
  end

  frame_addr_cnt #(.ADDR_WIDTH(ADDR_WIDTH), .MEM_DEPTH(MEM_DEPTH)) u_wr_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (wr_acc && !wr_last),
    .clr   (wr_done),
    .cnt   (wr_cnt),
    .last  (wr_last)
  );

  frame_addr_cnt #(.ADDR_WIDTH(ADDR_WIDTH), .MEM_DEPTH(MEM_DEPTH)) u_rd_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (rd_acc && !rd_last),
    .clr   (rd_done),
    .cnt   (rd_cnt),
    .last  (rd_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb        <= '0;
      rb        <= '0;
      full      <= '0;
      wr_state  <= W_FILL;
      rd_state  <= R_IDLE;
      frame_cnt <= '0;
    end else begin
      full <= full_nxt;
      if (wr_done) begin
        wb        <= wb_next;
        frame_cnt <= frame_cnt + 8'd1;
      end
      if (rd_done)
        rb <= rb_next;

      case (wr_state)
        W_FILL:
          // Look at the post-update flag so a same-cycle reader release of
          // the next bank keeps the writer filling.
          if (wr_done && full_nxt[wb_next])
            wr_state <= W_WAIT;
        W_WAIT:
          // Reacts to the registered flag, one cycle after the bank frees.
          if (!full[wb])
            wr_state <= W_FILL;
        default:
          wr_state <= W_FILL;
      endcase

      // frame_rdy is this register, so it trails full[rb] by one cycle.
      rd_state <= full[rb] ? R_READ : R_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en       <= 1'b0;
      rd_en       <= 1'b0;
      wr_addr     <= '0;
      rd_addr     <= '0;
      wr_drop     <= 1'b0;
      rd_underrun <= 1'b0;
    end else begin
      wr_en       <= wr_acc;
      rd_en       <= rd_acc;
      wr_drop     <= wr_rej;
      rd_underrun <= rd_rej;
      if (wr_acc) wr_addr <= {wb, wr_cnt};
      if (rd_acc) rd_addr <= {rb, rd_cnt};
    end
  end

  assign frame_rdy = (rd_state == R_READ);

endmodule

// File: tb/tb_frame_buf_ctrl.sv
module tb_frame_buf_ctrl;

  localparam int AW = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_req = 1'b0;
  logic        rd_req = 1'b0;
  logic        wr_en, rd_en, frame_rdy, wr_drop, rd_underrun;
  logic [AW:0] wr_addr, rd_addr;
  logic [7:0]  frame_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  frame_buf_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_req      (wr_req),
    .rd_req      (rd_req),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .frame_rdy   (frame_rdy),
    .wr_drop     (wr_drop),
    .rd_underrun (rd_underrun),
    .frame_cnt   (frame_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".wr_en"},       32'(wr_en),       32'd0);
    chk({tag, ".rd_en"},       32'(rd_en),       32'd0);
    chk({tag, ".wr_addr"},     32'(wr_addr),     32'd0);
    chk({tag, ".rd_addr"},     32'(rd_addr),     32'd0);
    chk({tag, ".frame_rdy"},   32'(frame_rdy),   32'd0);
    chk({tag, ".wr_drop"},     32'(wr_drop),     32'd0);
    chk({tag, ".rd_underrun"}, 32'(rd_underrun), 32'd0);
    chk({tag, ".frame_cnt"},   32'(frame_cnt),   32'd0);
  endtask

  task automatic do_reset;
    wr_req = 1'b0;
    rd_req = 1'b0;
    reset  = 1'b1;
    tick;
    tick;
    reset  = 1'b0;
  endtask

  initial begin
    // reset values
    #2 reset = 1'b1;
    #1 chk_all_zero("rst");
    tick;
    reset = 1'b0;

    // read with nothing written
    rd_req = 1'b1;
    tick;
    chk("underrun.pulse", 32'(rd_underrun), 32'd1);
    chk("underrun.rd_en", 32'(rd_en), 32'd0);
    rd_req = 1'b0;
    tick;
    chk("underrun.clear", 32'(rd_underrun), 32'd0);

    // first frame into bank 0
    for (int i = 0; i < 8; i++) begin
      wr_req = 1'b1;
      tick;
      chk("fill0.wr_en", 32'(wr_en), 32'd1);
      chk("fill0.wr_addr", 32'(wr_addr), 32'(i));
      chk("fill0.frame_rdy", 32'(frame_rdy), 32'd0);
    end
    chk("fill0.frame_cnt", 32'(frame_cnt), 32'd1);
    wr_req = 1'b0;
    tick;
    chk("fill0.rdy_late", 32'(frame_rdy), 32'd1);
    chk("fill0.wr_en_off", 32'(wr_en), 32'd0);

    // second frame into bank 1
    for (int i = 8; i < 16; i++) begin
      wr_req = 1'b1;
      tick;
      chk("fill1.wr_en", 32'(wr_en), 32'd1);
      chk("fill1.wr_addr", 32'(wr_addr), 32'(i));
    end
    chk("fill1.frame_cnt", 32'(frame_cnt), 32'd2);

    // both banks full: writes are dropped
    for (int i = 0; i < 3; i++) begin
      wr_req = 1'b1;
      tick;
      chk("wait.wr_drop", 32'(wr_drop), 32'd1);
      chk("wait.wr_en", 32'(wr_en), 32'd0);
    end
    wr_req = 1'b0;
    tick;
    chk("wait.drop_off", 32'(wr_drop), 32'd0);
    chk("wait.frame_cnt", 32'(frame_cnt), 32'd2);

    // drain bank 0
    for (int i = 0; i < 8; i++) begin
      rd_req = 1'b1;
      tick;
      chk("drain.rd_en", 32'(rd_en), 32'd1);
      chk("drain.rd_addr", 32'(rd_addr), 32'(i));
      chk("drain.underrun", 32'(rd_underrun), 32'd0);
    end
    rd_req = 1'b0;
    tick;
    chk("drain.rd_en_off", 32'(rd_en), 32'd0);
    chk("drain.frame_rdy", 32'(frame_rdy), 32'd1);

    // writer resumes in bank 0
    wr_req = 1'b1;
    tick;
    chk("resume.wr_en", 32'(wr_en), 32'd1);
    chk("resume.wr_addr", 32'(wr_addr), 32'd0);
    chk("resume.wr_drop", 32'(wr_drop), 32'd0);
    wr_req = 1'b0;
    tick;
    chk("resume.frame_rdy", 32'(frame_rdy), 32'd1);

    // reset mid-frame
    do_reset;
    for (int i = 0; i < 5; i++) begin
      wr_req = 1'b1;
      tick;
      chk("part.wr_addr", 32'(wr_addr), 32'(i));
    end
    reset = 1'b1;
    #1 chk_all_zero("midrst");
    tick;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr_req = 1'b1;
      tick;
      chk("refill.wr_en", 32'(wr_en), 32'd1);
      chk("refill.wr_addr", 32'(wr_addr), 32'(i));
      if (i == 0) chk("refill.frame_cnt0", 32'(frame_cnt), 32'd0);
    end
    chk("refill.frame_cnt", 32'(frame_cnt), 32'd1);

    // continuous streaming, reader one frame behind the writer
    rd_req = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick;
      chk("stream.wr_en", 32'(wr_en), 32'd1);
      chk("stream.rd_en", 32'(rd_en), 32'd1);
      chk("stream.wr_addr", 32'(wr_addr), 32'((8 + k) % 16));
      chk("stream.rd_addr", 32'(rd_addr), 32'(k % 16));
      chk("stream.wr_drop", 32'(wr_drop), 32'd0);
      chk("stream.underrun", 32'(rd_underrun), 32'd0);
      chk("stream.bank_split", 32'(wr_addr[AW] ^ rd_addr[AW]), 32'd1);
    end
    chk("stream.frame_cnt", 32'(frame_cnt), 32'd3);

    // frame_cnt wraps
    repeat (2016) tick;
    chk("wrap.cnt255", 32'(frame_cnt), 32'd255);
    chk("wrap.no_drop", 32'(wr_drop), 32'd0);
    repeat (8) tick;
    chk("wrap.cnt0", 32'(frame_cnt), 32'd0);
    chk("wrap.no_underrun", 32'(rd_underrun), 32'd0);

    wr_req = 1'b0;
    rd_req = 1'b0;
    tick;
    chk("idle.wr_en", 32'(wr_en), 32'd0);
    chk("idle.rd_en", 32'(rd_en), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
